int_divider_unit: RTL



---
 rtl/int_divider_unit_if.sv | 33 +++
 rtl/int_divider_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/int_divider_unit_if.sv
// Issue/result handshake bundle for the iterative integer divider.
// slave: divider side (takes issue, drives result); master: RS/CDB side.
interface int_divider_unit_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [TAG_W-1:0] in_tag;
    logic             in_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, in_tag, in_signed,
        output dividend, divisor, out_ready,
        input  in_ready, out_valid, out_tag,
        input  quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, in_tag, in_signed,
        input  dividend, divisor, out_ready,
        output in_ready, out_valid, out_tag,
        output quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/int_divider_unit.sv
// Iterative radix-2 restoring divider: WIDTH CALC cycles, one FIX cycle.
// Ports: clk, rst (sync, active-high), flush, bus (slave handshake bundle).
module int_divider_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    int_divider_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dmag;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_n;
    logic             r_neg_d;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Sign flags are pre-gated by in_signed, so unsigned ops see no fix-up.
    assign w_a_neg = bus.in_signed & bus.dividend[WIDTH-1];
    assign w_b_neg = bus.in_signed & bus.divisor[WIDTH-1];
    assign w_a_mag = w_a_neg ? -bus.dividend : bus.dividend;
    assign w_b_mag = w_b_neg ? -bus.divisor : bus.divisor;

    // One extra bit: the shifted remainder can exceed WIDTH bits
    // when the divisor magnitude is above 2^(WIDTH-1).
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dmag};

    assign w_q_fix = (r_neg_n ^ r_neg_d) ? -r_quo : r_quo;
    assign w_r_fix = r_neg_n ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dmag      <= '0;
            r_cnt       <= '0;
            r_neg_n     <= 1'b0;
            r_neg_d     <= 1'b0;
            r_out_tag   <= '0;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_out_tag <= bus.in_tag;
                        r_neg_n   <= w_a_neg;
                        r_neg_d   <= w_b_neg;
                        r_quo     <= w_a_mag;
                        r_dmag    <= w_b_mag;
                        r_rem     <= '0;
                        r_cnt     <= CW'(WIDTH - 1);
                        if (bus.divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend;
                            r_dbz       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                FIX: begin
                    r_quotient  <= w_q_fix;
                    r_remainder <= w_r_fix;
                    r_dbz       <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.out_valid   = r_out_valid;
    assign bus.out_tag     = r_out_tag;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule
